// File: rtl/adc_deser_pkg.sv
// adc_deser_pkg
// Shared types and helpers for the multi-lane ADC deserializer.
//   deser_state_t : frame aligner FSM state (SEARCH / LOCKED)
//   fco_pattern() : expected FCO word, upper half ones, lower half zeros
//   cnt_width()   : bits needed to hold a count up to and including max_val
// Optional feature macro used by the top: ADC_DESER_PATTERN_CHK_EN.

package adc_deser_pkg;

  localparam int DESER_MIN_WIDTH = 8;
  localparam int DESER_MAX_WIDTH = 16;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } deser_state_t;

  // Returned at the maximum width; callers take the low 'width' bits.
  function automatic logic [DESER_MAX_WIDTH-1:0] fco_pattern(input int width);
    logic [DESER_MAX_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < DESER_MAX_WIDTH; i++) begin
      if ((i >= width / 2) && (i < width)) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner
// Finds the word boundary from the FCO lane and tracks lock.
// Owns the FCO history, the parallel offset search, the free-running
// phase counter, the SEARCH/LOCKED FSM, good/bad counters, slip and locked.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEARCH | scanning all offsets each tick, counting repeat matches
//   ST_LOCKED | offset fixed at slip, words emitted each tick, FCO checked
//
// Ports:
//   clk, rstn    bit clock (DCO domain), async active-low reset
//   i_fco_q[1:0] FCO DDR pair, [1] earlier bit
//   i_realign    pulse forcing a re-search
//   o_emit       comb: register lane windows into the output this cycle
//   o_slip       selected bit offset
//   o_locked     alignment locked

module adc_frame_aligner
  import adc_deser_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter bit FCO_INVERTED = 1'b0,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [1:0]                    i_fco_q,
  input  logic                          i_realign,
  output logic                          o_emit,
  output logic [$clog2(DATA_WIDTH)-1:0] o_slip,
  output logic                          o_locked
);

  localparam int W      = DATA_WIDTH;
  localparam int HALF   = W / 2;
  // Only the newest 2W-1 bits can ever fall inside a window (offset W-1
  // reaches bit 2W-2), so the register keeps 2W-3 bits and the incoming
  // pair completes the view.
  localparam int HW     = 2 * W - 1;
  localparam int SLIP_W = $clog2(W);
  localparam int PH_W   = cnt_width(HALF - 1);
  localparam int GC_W   = cnt_width(LOCK_COUNT);
  localparam int BC_W   = cnt_width(UNLOCK_COUNT);

  localparam logic [DESER_MAX_WIDTH-1:0] FCO_PAT_FULL = fco_pattern(W);
  localparam logic [W-1:0]               FCO_PAT      = FCO_PAT_FULL[W-1:0];

  deser_state_t      r_state;
  logic [PH_W-1:0]   r_phase;
  logic [HW-3:0]     r_fhist;
  logic [HW-1:0]     w_fhist_next;
  logic [SLIP_W-1:0] r_slip;
  logic [SLIP_W-1:0] r_cand;
  logic [SLIP_W-1:0] w_m;
  logic [GC_W-1:0]   r_good;
  logic [GC_W-1:0]   w_good_next;
  logic [BC_W-1:0]   r_bad;
  logic [BC_W-1:0]   w_bad_next;
  logic              r_locked;
  logic              w_tick;
  logic              w_match;
  logic              w_slip_ok;
  logic              w_unlock;

  // Windows are taken from the history including this cycle's pair, so a
  // word whose last pair arrives on the tick is available right after it.
  assign w_fhist_next = {r_fhist, i_fco_q ^ {2{FCO_INVERTED}}};
  assign w_tick       = (r_phase == PH_W'(HALF - 1));
  assign w_slip_ok    = (w_fhist_next[r_slip +: W] == FCO_PAT);

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    w_match = 1'b0;
    w_m     = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (w_fhist_next[k +: W] == FCO_PAT) begin
        w_match = 1'b1;
        w_m     = SLIP_W'(k);
      end
    end
  end

  always_comb begin
    if (!w_match)
      w_good_next = '0;
    else if (w_m == r_cand)
      w_good_next = (r_good == GC_W'(LOCK_COUNT)) ? r_good : r_good + 1'b1;
    else
      w_good_next = GC_W'(1);
  end

  assign w_bad_next = (r_bad == BC_W'(UNLOCK_COUNT)) ? r_bad : r_bad + 1'b1;

  assign w_unlock = (r_state == ST_LOCKED) && w_tick && !w_slip_ok &&
                    (w_bad_next == BC_W'(UNLOCK_COUNT));

  // The frame that causes unlock is dropped; realign wins over a tick.
  assign o_emit = (r_state == ST_LOCKED) && w_tick && !i_realign && !w_unlock;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_SEARCH;
      r_phase  <= '0;
      r_fhist  <= '0;
      r_slip   <= '0;
      r_cand   <= '0;
      r_good   <= '0;
      r_bad    <= '0;
      r_locked <= 1'b0;
    end else begin
      r_phase <= w_tick ? '0 : r_phase + 1'b1;
      r_fhist <= w_fhist_next[HW-3:0];
      if (i_realign) begin
        r_state  <= ST_SEARCH;
        r_locked <= 1'b0;
        r_good   <= '0;
        r_bad    <= '0;
        r_cand   <= '0;
      end else if (w_tick) begin
        case (r_state)
          ST_SEARCH: begin
            r_good <= w_good_next;
            if (w_match) r_cand <= w_m;
            if (w_good_next == GC_W'(LOCK_COUNT)) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_slip   <= w_m;
              r_bad    <= '0;
            end
          end
          ST_LOCKED: begin
            if (w_slip_ok) begin
              r_bad <= '0;
            end else if (w_unlock) begin
              r_state  <= ST_SEARCH;
              r_locked <= 1'b0;
              r_good   <= '0;
              r_bad    <= '0;
            end else begin
              r_bad <= w_bad_next;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign o_slip   = r_slip;
  assign o_locked = r_locked;

endmodule

// File: rtl/adc_multi_deser.sv
// adc_multi_deser
// Frame-aligned deserializer for NUM_CH serial-LVDS ADC lanes plus FCO.
// Lane histories, polarity inversion, window mux and the output word
// register live here; boundary search and lock live in adc_frame_aligner.
// Optional macro ADC_DESER_PATTERN_CHK_EN builds a sticky per-lane compare
// of every output word against CHK_PATTERN; otherwise pattern_err is 0.
//
// Ports:
//   clk          bit clock (DCO domain), rising edge
//   rstn         async active-low reset
//   din_q        DDR pairs, lane c at [2c+1] (earlier) / [2c] (later)
//   fco_q        FCO DDR pair, [1] earlier
//   realign      pulse forcing a re-search (also clears pattern_err)
//   des_data     aligned words, lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   des_valid    one-cycle strobe when des_data updates
//   locked       alignment locked
//   slip         selected bit offset
//   pattern_err  sticky per-lane test-pattern error

module adc_multi_deser
  import adc_deser_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                DATA_WIDTH   = 12,
  parameter logic [NUM_CH-1:0] DIN_INV_MASK = '0,
  parameter bit                FCO_INVERTED = 1'b0,
  parameter int                LOCK_COUNT   = 4,
  parameter int                UNLOCK_COUNT = 2
`ifdef ADC_DESER_PATTERN_CHK_EN
  , parameter logic [DATA_WIDTH-1:0] CHK_PATTERN = DATA_WIDTH'(12'hA5C)
`endif
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [2*NUM_CH-1:0]          din_q,
  input  logic [1:0]                   fco_q,
  input  logic                         realign,
  output logic [NUM_CH*DATA_WIDTH-1:0] des_data,
  output logic                         des_valid,
  output logic                         locked,
  output logic [$clog2(DATA_WIDTH)-1:0] slip,
  output logic [NUM_CH-1:0]            pattern_err
);

  localparam int W  = DATA_WIDTH;
  localparam int HW = 2 * W - 1;

  logic                    w_emit;
  logic [$clog2(W)-1:0]    w_slip;
  logic                    w_locked;
  logic [NUM_CH*W-1:0]     w_win_all;
  logic [NUM_CH*W-1:0]     r_des_data;
  logic                    r_des_valid;

  adc_frame_aligner #(
    .DATA_WIDTH   (DATA_WIDTH),
    .FCO_INVERTED (FCO_INVERTED),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_aligner (
    .clk       (clk),
    .rstn      (rstn),
    .i_fco_q   (fco_q),
    .i_realign (realign),
    .o_emit    (w_emit),
    .o_slip    (w_slip),
    .o_locked  (w_locked)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [HW-3:0] r_hist;
    logic [HW-1:0] w_hist_next;

    assign w_hist_next = {r_hist, din_q[2*c+1 -: 2] ^ {2{DIN_INV_MASK[c]}}};
    assign w_win_all[c*W +: W] = w_hist_next[w_slip +: W];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_hist <= '0;
      else       r_hist <= w_hist_next[HW-3:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_des_data  <= '0;
      r_des_valid <= 1'b0;
    end else begin
      r_des_valid <= w_emit;
      if (w_emit) r_des_data <= w_win_all;
    end
  end

`ifdef ADC_DESER_PATTERN_CHK_EN
  logic [NUM_CH-1:0] r_pat_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pat_err <= '0;
    end else if (realign) begin
      r_pat_err <= '0;
    end else if (w_emit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_win_all[c*W +: W] != CHK_PATTERN) r_pat_err[c] <= 1'b1;
      end
    end
  end

  assign pattern_err = r_pat_err;
`else
  assign pattern_err = '0;
`endif

  assign des_data  = r_des_data;
  assign des_valid = r_des_valid;
  assign locked    = w_locked;
  assign slip      = w_slip;

endmodule

// File: doc/adc_multi_deser.md
Name: adc_multi_deser

Overview:
- Parametrised multi-channel frame-aligned deserializer for serial-LVDS ADCs in the AD9228 family.
- Takes DDR bit pairs already captured by IDDRs in the DCO domain, for NUM_CH data lanes plus the FCO lane.
- Finds the word boundary at single-bit granularity from the FCO pattern, then emits aligned parallel words with a valid strobe.
- Tracks lock and loses it on repeated FCO errors.
- Sits between the per-lane IDDR capture and the sample FIFO / trigger logic.

Parameters:
- NUM_CH, 4, number of ADC data lanes.
- DATA_WIDTH, 12, bits per sample; must be even, range 8..16.
- DIN_INV_MASK, '0 (NUM_CH bits), per-lane polarity inversion; bit c inverts lane c.
- FCO_INVERTED, 0, inverts the FCO lane.
- LOCK_COUNT, 4, consecutive matching frames required to lock.
- UNLOCK_COUNT, 2, consecutive mismatching frames that drop lock.

Ports:
- clk  in  1  bit clock (DCO domain), rising edge only.
- rstn  in  1  reset, asynchronous assert, active low.
- din_q  in  2*NUM_CH  DDR pairs for each lane. For lane c, bit [2c+1] is the earlier bit and bit [2c] is the later bit.
- fco_q  in  2  FCO DDR pair; [1] is the earlier bit.
- realign  in  1  single-cycle pulse that forces a re-search.
- des_data  out  NUM_CH*DATA_WIDTH  aligned words; lane c occupies [c*DATA_WIDTH +: DATA_WIDTH], MSB first in time.
- des_valid  out  1  one-cycle strobe when des_data updates.
- locked  out  1  alignment locked.
- slip  out  $clog2(DATA_WIDTH)  selected bit offset.
- pattern_err  out  NUM_CH  sticky per-lane pattern-check error (see Optional Feature).

Behaviour:
- Reset (async, rstn=0): all outputs 0, all internal histories and counters 0, state SEARCH.
- Defined constants: W = DATA_WIDTH, HALF = W/2.
- FCO_PATTERN: upper HALF bits 1, lower HALF bits 0 (0xFC0 for W=12).
- History capture:
  - Each lane, and FCO, has a 2W-bit history register.
  - Every clk it shifts left by 2 and inserts {earlier, later} into bits [1:0], after applying polarity inversion.
- Window at offset k (0..W-1) = hist[k+W-1:k].
- Phase counter: runs 0..HALF-1 and wraps. It runs free in all states. A "tick" is the cycle where phase == HALF-1.
- FSM state SEARCH:
  - On each tick, m = lowest k whose FCO window equals FCO_PATTERN.
  - If a match exists and m equals the previous candidate, increment good_cnt. Otherwise set candidate = m and good_cnt = 1 if a match exists, else 0.
  - When good_cnt reaches LOCK_COUNT: go to LOCKED, set slip = candidate, assert locked.
  - des_valid stays 0 throughout SEARCH.
- FSM state LOCKED:
  - On each tick, register the lane windows at offset slip into des_data and pulse des_valid the following cycle.
  - des_valid period is exactly HALF clks.
  - If the FCO window at slip mismatches, increment bad_cnt; a match clears it.
  - When bad_cnt reaches UNLOCK_COUNT, go to SEARCH: locked=0, good_cnt=0, no valid on that tick.
  - The word from the mismatching frame that triggers unlock is not output. Words from earlier mismatching frames are still output.
- Hold behaviour: des_data holds its last value when not updating; slip holds while in SEARCH.
- realign:
  - The next cycle enters SEARCH with counters cleared; locked deasserts in that cycle.
  - realign takes priority over a simultaneous tick.
- Latency: the last bit pair of a word is captured at cycle t (the tick). des_data and des_valid appear at t+1.
- Reset mid-operation: immediate clear, no partial word is emitted after release. The first possible lock is LOCK_COUNT ticks after reset release.
- good_cnt and bad_cnt saturate; they do not wrap.

Optional Feature:
- Macro: ADC_DESER_PATTERN_CHK_EN.
- Enabled:
  - Adds parameter CHK_PATTERN (W bits, default 12'hA5C, from the ADC user test mode).
  - Each valid word on lane c that differs from CHK_PATTERN sets pattern_err[c].
  - pattern_err is sticky and is cleared by realign or reset.
- Disabled: pattern_err is tied 0 and no compare logic is built.

Decomposition:
- Package adc_deser_pkg holds:
  - the state enum (SEARCH, LOCKED);
  - a function fco_pattern(width);
  - width helper constants.
- One sub-module, adc_frame_aligner, owns the FCO history, the parallel offset search, the FSM, the counters, slip and locked.
- The top module owns the lane histories, inversion, window mux, des_data/des_valid and the pattern check.

Test Plan:
1. Hold rstn=0 for 5 clk with random inputs -> des_data=0, des_valid=0, locked=0, slip=0. Release -> locked stays 0 for at least 4 ticks.
2. NUM_CH=2, W=12, offset 0, FCO 0xFC0, ch0 0xA5C, ch1 0x123 -> locked after the 4th tick with slip=0. des_valid every 6 clk, des_data={12'h123,12'hA5C}.
3. Same stream delayed by 3 bits -> slip=3 and identical decoded words. Repeat for offsets 0..11 -> slip equals the offset.
4. While locked, corrupt FCO in 2 consecutive frames -> locked=0 after the 2nd bad tick with no valid for that frame. Then 4 good frames -> relock.
5. DIN_INV_MASK=2'b10, ch1 driven with ~0x123 -> ch1 output 0x123, ch0 unchanged.
6. While locked, pulse realign -> locked=0 next clk, relock after 4 ticks. With ADC_DESER_PATTERN_CHK_EN, one 0xA5D word on ch0 -> pattern_err=2'b01, cleared by realign.
